data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, sets storage size in 64-bit doublewords and SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, sets the wait states between request acceptance and response; legal range is 0..15.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address (core ALU result).
REQ-009 req_size  input  3  funct3 code: 0 = B, 1 = H, 2 = W, 3 = D, 4 = BU, 5 = HU, 6 = WU.
REQ-010 req_wdata  input  64  store data (core rs2); only the low bytes selected by the size are used.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  64  load result, extended to 64 bits.
REQ-014 rsp_err  output  1  request was misaligned or had an illegal size.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 rsp_valid SHALL be 1 only in RESP.
REQ-018 Acceptance occurs when req_valid and req_ready are both 1; addr, size, write and wdata SHALL be latched on that edge.
REQ-019 On acceptance the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or go directly to RESP when WAIT_CYCLES = 0.
REQ-020 In WAIT the counter SHALL decrement each cycle; on the cycle the counter is 0 the FSM SHALL move to RESP.
REQ-021 Latency from the acceptance edge to rsp_valid high SHALL be exactly WAIT_CYCLES+1 clock edges.
REQ-022 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-023 A new request SHALL NOT be accepted in the same cycle a response completes; back-to-back throughput is one request per WAIT_CYCLES+2 cycles minimum.
REQ-024 Storage index SHALL be addr[log2(DEPTH)+2:3] and byte lane addr[2:0]; addresses beyond DEPTH*8 SHALL wrap silently.
REQ-025 A request SHALL be an error if: H/HU with addr[0]≠0; W/WU with addr[1:0]≠0; D with addr[2:0]≠0; size code 7; or a store with size code 4..6.
REQ-026 An error request SHALL NOT modify storage and SHALL return rsp_rdata=0 with rsp_err=1.
REQ-027 A legal store SHALL update only the addressed byte lanes, on the edge entering RESP.
REQ-028 A legal load SHALL capture data on the edge entering RESP.
REQ-029 Loads with codes 0..2 SHALL sign-extend; codes 4..6 SHALL zero-extend; D SHALL return the full doubleword.
REQ-030 Legal stores SHALL return rsp_rdata=0 and rsp_err=0.
REQ-031 A load issued after a store to the same address SHALL return the stored value (no stale data).
REQ-032 Inputs other than rsp_ready SHALL be ignored outside the acceptance cycle.

Reset
REQ-033 While rst_n=0: FSM=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-034 Reset asserted mid-transaction (WAIT or RESP) SHALL abandon the transaction; a store not yet committed SHALL NOT be written.
REQ-035 Storage contents SHALL NOT be reset.

Structure
REQ-036 Size codes, FSM state encoding and the default DEPTH/WAIT_CYCLES SHALL live in a shared package used by core and responder.
REQ-037 Byte-lane write-mask generation and load extension SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-038 Store D 0x1122334455667788 @0x10, then load D @0x10 -> rdata 0x1122334455667788, err 0, response 3 edges after acceptance (WAIT_CYCLES=2).
REQ-039 Store B 0x80 @0x13, then load B @0x13 -> 0xFFFFFFFFFFFFFF80; load BU @0x13 -> 0x80; load D @0x10 -> 0x1122334480667788.
REQ-040 Load W @0x12 -> err 1, rdata 0; store H @0x11 -> err 1, and a following load D @0x10 is unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next edge.
REQ-042 Assert rst_n=0 while in WAIT of store D 0xAA @0x20 -> outputs at reset values; after release, load D @0x20 returns the pre-store value.
REQ-043 With WAIT_CYCLES=0, store @0x800 (DEPTH=256) then load @0x0 -> returns the stored data (wrap), 1-edge latency.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: load/store size codes,
// FSM state encoding, default geometry/timing and the request legality check.
package data_mem_responder_pkg;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_D  = 3'd3;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;
  localparam logic [2:0] SZ_WU = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Unsigned sizes only exist for loads; code 7 is never legal.
  function automatic logic size_err(input logic [2:0] size, input logic write,
                                    input logic [2:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      SZ_BU:   return write;
      SZ_HU:   return write | lane[0];
      SZ_WU:   return write | (|lane[1:0]);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane helper: builds the store write mask and aligned store data, and
// shifts/extends a stored doubleword into a 64-bit load result.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_al,
  output logic [63:0] rdata_ext
);

  logic [5:0]  shamt;
  logic [63:0] rshift;

  assign shamt    = {lane, 3'b000};
  assign wdata_al = wdata << shamt;
  assign rshift   = rword >> shamt;

  // Unsigned codes get no mask since they are never legal stores.
  always_comb begin
    wmask     = 8'h00;
    rdata_ext = 64'h0;
    case (size)
      SZ_B: begin
        wmask     = 8'h01 << lane;
        rdata_ext = {{56{rshift[7]}}, rshift[7:0]};
      end
      SZ_H: begin
        wmask     = 8'h03 << lane;
        rdata_ext = {{48{rshift[15]}}, rshift[15:0]};
      end
      SZ_W: begin
        wmask     = 8'h0f << lane;
        rdata_ext = {{32{rshift[31]}}, rshift[31:0]};
      end
      SZ_D: begin
        wmask     = 8'hff;
        rdata_ext = rword;
      end
      SZ_BU:   rdata_ext = {56'h0, rshift[7:0]};
      SZ_HU:   rdata_ext = {48'h0, rshift[15:0]};
      SZ_WU:   rdata_ext = {32'h0, rshift[31:0]};
      default: rdata_ext = 64'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed wait states; stores and
// loads take effect on the edge entering RESP so an aborted request leaves no trace.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]    state_q;
  logic [3:0]    cnt_q;
  logic [AW+2:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic [63:0]   wdata_q;

  logic [63:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          commit;
  logic [AW+2:0] op_addr;
  logic [2:0]    op_size;
  logic          op_write;
  logic [63:0]   op_wdata;
  logic [AW-1:0] op_idx;
  logic          op_err;
  logic [63:0]   rword;
  logic [7:0]    wmask;
  logic [63:0]   wdata_al;
  logic [63:0]   rdata_ext;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+3];

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the operation completes on the acceptance edge,
  // so the live request fields must feed the datapath while in IDLE.
  assign op_addr  = (state_q == ST_IDLE) ? req_addr[AW+2:0] : addr_q;
  assign op_size  = (state_q == ST_IDLE) ? req_size  : size_q;
  assign op_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign op_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign op_idx   = op_addr[AW+2:3];
  assign op_err   = size_err(op_size, op_write, op_addr[2:0]);
  assign rword    = mem[op_idx];

  assign enter_resp = (accept && NO_WAIT) || (state_q == ST_WAIT && cnt_q == 4'd0);
  assign commit     = enter_resp && rst_n && op_write && !op_err;

  mem_lane_align u_align (
    .size      (op_size),
    .lane      (op_addr[2:0]),
    .wdata     (op_wdata),
    .rword     (rword),
    .wmask     (wmask),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) mem[op_idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      size_q    <= 3'd0;
      write_q   <= 1'b0;
      wdata_q   <= 64'h0;
      rsp_rdata <= 64'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr[AW+2:0];
        size_q  <= req_size;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (enter_resp) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_write) ? 64'h0 : rdata_ext;
      end
    end
  end

endmodule
